// File: rtl/fir_datapath_pkg.sv
// Shared definitions for the 4-tap FIR datapath: tap/coefficient select
// encodings and the default coefficient set.
package fir_datapath_pkg;

    typedef enum logic [1:0] {
        TAP0 = 2'b00,
        TAP1 = 2'b01,
        TAP2 = 2'b10,
        TAP3 = 2'b11
    } tap_sel_e;

    localparam int NUM_TAPS  = 4;
    localparam int DEF_COEF0 = 1;
    localparam int DEF_COEF1 = 2;
    localparam int DEF_COEF2 = 3;
    localparam int DEF_COEF3 = 4;

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate unit for the FIR datapath: signed tap*coef product,
// sign-extended into a wrapping accumulator with clear / clear-and-load.
module fir_mac
    import fir_datapath_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = DATA_W + COEF_W + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sum_clr,
    input  logic                     sum_ld,
    input  logic signed [DATA_W-1:0] tap,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  acc_next;

    assign prod     = tap * coef;
    assign prod_ext = ACC_W'(prod);

    // Next accumulator value: clear-and-load beats plain clear beats accumulate.
    always_comb begin
        acc_next = acc_reg;
        if (sum_clr && sum_ld) begin
            acc_next = prod_ext;
        end else if (sum_clr) begin
            acc_next = '0;
        end else if (sum_ld) begin
            acc_next = acc_reg + prod_ext;
        end
    end

    // Accumulator register; reset discards any partial sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/fir_datapath.sv
// 4-tap FIR datapath: delay line, coefficient select, MAC and output stage.
// Build option: define FIR_SAT_EN to clamp out-of-range results instead of
// wrapping them to DATA_W bits.
module fir_datapath
    import fir_datapath_pkg::*;
#(
    parameter int                 DATA_W = 8,
    parameter int                 COEF_W = 8,
    parameter logic signed [COEF_W-1:0] COEF0 = COEF_W'(DEF_COEF0),
    parameter logic signed [COEF_W-1:0] COEF1 = COEF_W'(DEF_COEF1),
    parameter logic signed [COEF_W-1:0] COEF2 = COEF_W'(DEF_COEF2),
    parameter logic signed [COEF_W-1:0] COEF3 = COEF_W'(DEF_COEF3),
    parameter int                 ACC_W  = DATA_W + COEF_W + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     x_ld,
    input  logic                     sum_clr,
    input  logic                     sum_ld,
    input  logic [1:0]               mult_sel,
    input  logic                     y_ld,
    input  logic signed [DATA_W-1:0] x_in,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     y_valid,
    output logic                     primed,
    output logic                     ovf
);

    localparam logic [2:0] FILL_MAX = 3'(NUM_TAPS);
    localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] tap_reg [NUM_TAPS];
    logic [2:0]               fill_reg;
    logic signed [DATA_W-1:0] y_out_reg;
    logic                     y_valid_reg;
    logic                     ovf_reg;

    logic signed [DATA_W-1:0] tap_sel;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [ACC_W-1:0]  acc;
    logic                     in_range;
    logic signed [DATA_W-1:0] y_next;

    // Delay line: tap0 takes the new sample, older samples move one place down.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                tap_reg[i] <= '0;
            end
        end else if (x_ld) begin
            tap_reg[0] <= x_in;
            for (int i = 1; i < NUM_TAPS; i++) begin
                tap_reg[i] <= tap_reg[i-1];
            end
        end
    end

    // Fill counter saturates once the delay line holds four real samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_reg <= '0;
        end else if (x_ld && (fill_reg != FILL_MAX)) begin
            fill_reg <= fill_reg + 3'd1;
        end
    end

    // Tap and coefficient select; taps are registers so the MAC always sees
    // pre-shift values even when x_ld fires in the same cycle.
    always_comb begin
        tap_sel  = tap_reg[0];
        coef_sel = COEF0;
        case (tap_sel_e'(mult_sel))
            TAP0:    begin tap_sel = tap_reg[0]; coef_sel = COEF0; end
            TAP1:    begin tap_sel = tap_reg[1]; coef_sel = COEF1; end
            TAP2:    begin tap_sel = tap_reg[2]; coef_sel = COEF2; end
            TAP3:    begin tap_sel = tap_reg[3]; coef_sel = COEF3; end
            default: begin tap_sel = tap_reg[0]; coef_sel = COEF0; end
        endcase
    end

    fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .sum_clr (sum_clr),
        .sum_ld  (sum_ld),
        .tap     (tap_sel),
        .coef    (coef_sel),
        .acc     (acc)
    );

    // Accumulator fits DATA_W iff all bits from the DATA_W sign bit upward agree.
    assign in_range = (&acc[ACC_W-1:DATA_W-1]) | ~(|acc[ACC_W-1:DATA_W-1]);

    // Output value for a capture: clamp or wrap depending on build.
    always_comb begin
        y_next = acc[DATA_W-1:0];
`ifdef FIR_SAT_EN
        if (!in_range) begin
            y_next = acc[ACC_W-1] ? Y_MIN : Y_MAX;
        end
`endif
    end

    // Output stage: capture pre-update acc, pulse valid next cycle, sticky ovf.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_out_reg   <= '0;
            y_valid_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            y_valid_reg <= y_ld;
            if (y_ld) begin
                y_out_reg <= y_next;
                if (!in_range) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign y_out   = y_out_reg;
    assign y_valid = y_valid_reg;
    assign primed  = (fill_reg == FILL_MAX);
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_fir_datapath.sv
// Directed, table-driven bench for fir_datapath (default coefficients 1,2,3,4).
// Expected wrap/saturate results follow the FIR_SAT_EN setting of the build.
module tb_fir_datapath;

    logic              clk;
    logic              reset;
    logic              x_ld;
    logic              sum_clr;
    logic              sum_ld;
    logic [1:0]        mult_sel;
    logic              y_ld;
    logic signed [7:0] x_in;
    logic signed [7:0] y_out;
    logic              y_valid;
    logic              primed;
    logic              ovf;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef FIR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        bit do_reset;
        int x;
        int exp_y_sat;
        int exp_y_wrap;
        int exp_primed;
        int exp_ovf;
    } vec_t;

    vec_t vecs [12];

    fir_datapath dut (
        .clk      (clk),
        .reset    (reset),
        .x_ld     (x_ld),
        .sum_clr  (sum_clr),
        .sum_ld   (sum_ld),
        .mult_sel (mult_sel),
        .y_ld     (y_ld),
        .x_in     (x_in),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .primed   (primed),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic idle();
        x_ld = 0; sum_clr = 0; sum_ld = 0; y_ld = 0; mult_sel = 2'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // One full frame: shift, clear-and-load tap0, accumulate taps 1..3, capture.
    task automatic run_frame(input int x);
        idle();
        x_ld = 1'b1; x_in = 8'(x);
        step();
        x_ld = 1'b0;
        sum_clr = 1'b1; sum_ld = 1'b1; mult_sel = 2'd0;
        step();
        sum_clr = 1'b0;
        for (int k = 1; k < 4; k++) begin
            mult_sel = 2'(k);
            step();
        end
        sum_ld = 1'b0; y_ld = 1'b1;
        step();
        y_ld = 1'b0;
    endtask

    initial begin
        //             rst  x     sat   wrap primed ovf
        vecs[0]  = '{1'b1,  10,   10,   10,  0, 0};
        vecs[1]  = '{1'b0,   0,   20,   20,  0, 0};
        vecs[2]  = '{1'b0,   0,   30,   30,  0, 0};
        vecs[3]  = '{1'b0,   0,   40,   40,  1, 0};
        vecs[4]  = '{1'b1, 127,  127,  127,  0, 0};
        vecs[5]  = '{1'b0, 127,  127,  125,  0, 1};
        vecs[6]  = '{1'b0, 127,  127,   -6,  0, 1};
        vecs[7]  = '{1'b0, 127,  127,  -10,  1, 1};
        vecs[8]  = '{1'b1,-128, -128, -128,  0, 0};
        vecs[9]  = '{1'b0,-128, -128, -128,  0, 1};
        vecs[10] = '{1'b0,-128, -128,    0,  0, 1};
        vecs[11] = '{1'b0,-128, -128,    0,  1, 1};

        reset = 1'b0;
        x_in  = '0;
        idle();

        // Reset state
        do_reset();
        check("reset y_out",   int'(y_out), 0);
        check("reset y_valid", int'(y_valid), 0);
        check("reset primed",  int'(primed), 0);
        check("reset ovf",     int'(ovf), 0);

        // Frame table: impulse, positive and negative overflow
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_reset) begin
                do_reset();
            end
            run_frame(vecs[i].x);
            check($sformatf("frame%0d y_out", i), int'(y_out),
                  SAT ? vecs[i].exp_y_sat : vecs[i].exp_y_wrap);
            check($sformatf("frame%0d y_valid", i), int'(y_valid), 1);
            check($sformatf("frame%0d primed", i), int'(primed), vecs[i].exp_primed);
            check($sformatf("frame%0d ovf", i), int'(ovf), vecs[i].exp_ovf);
            step();
            check($sformatf("frame%0d y_valid drop", i), int'(y_valid), 0);
        end

        // Idle cycles hold all state
        step();
        step();
        check("hold y_out", int'(y_out), SAT ? -128 : 0);
        check("hold primed", int'(primed), 1);
        check("hold ovf", int'(ovf), 1);

        // Mid-frame reset: partial sum and fill count discarded
        idle();
        x_ld = 1'b1; x_in = 8'sd9;
        step();
        x_ld = 1'b0; sum_clr = 1'b1; sum_ld = 1'b1; mult_sel = 2'd0;
        step();
        sum_clr = 1'b0; mult_sel = 2'd1;
        step();
        reset = 1'b1; sum_ld = 1'b1; x_ld = 1'b1; y_ld = 1'b1; mult_sel = 2'd2;
        step();
        reset = 1'b0;
        idle();
        check("midreset ovf", int'(ovf), 0);
        check("midreset y_valid", int'(y_valid), 0);
        run_frame(5);
        check("midreset y_out", int'(y_out), 5);
        check("midreset primed", int'(primed), 0);

        // Simultaneous strobes: taps become [0,0,0,10], acc = 40
        do_reset();
        run_frame(10);
        run_frame(0);
        run_frame(0);
        run_frame(0);
        check("simul setup y_out", int'(y_out), 40);
        idle();
        x_ld = 1'b1; x_in = 8'sd7; sum_clr = 1'b1; sum_ld = 1'b1; mult_sel = 2'd3;
        step();
        idle();
        sum_ld = 1'b1; mult_sel = 2'd0; y_ld = 1'b1;
        step();
        idle();
        check("simul x_ld+sum_ld pre-shift", int'(y_out), 40);
        check("simul y_valid", int'(y_valid), 1);
        y_ld = 1'b1;
        step();
        idle();
        check("simul y_ld+sum_ld pre-update", int'(y_out), 47);
        check("simul ovf", int'(ovf), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_datapath.md
FIR_DATAPATH -- requirements
Module: fir_datapath

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed sample width of x_in and y_out.
REQ-002 SHALL have parameter COEF_W, default 8, signed coefficient width.
REQ-003 SHALL have parameters COEF0..COEF3, defaults 1,2,3,4, tap coefficients h[0]..h[3].
REQ-004 SHALL have parameter ACC_W, default DATA_W+COEF_W+2, signed accumulator width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port x_ld  input  1  shift x_in into delay line.
REQ-008 SHALL have port sum_clr  input  1  clear accumulator.
REQ-009 SHALL have port sum_ld  input  1  accumulate h[mult_sel]*tap[mult_sel].
REQ-010 SHALL have port mult_sel  input  2  tap/coefficient select.
REQ-011 SHALL have port y_ld  input  1  capture accumulator to output.
REQ-012 SHALL have port x_in  input  DATA_W  signed sample.
REQ-013 SHALL have port y_out  output  DATA_W  signed filtered sample.
REQ-014 SHALL have port y_valid  output  1  one-cycle pulse per new y_out.
REQ-015 SHALL have port primed  output  1  delay line holds 4 real samples.
REQ-016 SHALL have port ovf  output  1  sticky: captured result exceeded DATA_W range.

Function
REQ-017 SHALL compute y = sum over k=0..3 of h[k]*x[n-k], with tap0 the newest sample.
REQ-018 On x_ld: tap3<=tap2, tap2<=tap1, tap1<=tap0, tap0<=x_in, in one cycle.
REQ-019 On sum_ld: acc<=acc + tap[mult_sel]*h[mult_sel], using pre-shift taps when x_ld is asserted in the same cycle.
REQ-020 sum_clr alone SHALL set acc<=0; sum_clr with sum_ld SHALL set acc<=product (clear-and-load).
REQ-021 On y_ld: capture the pre-update acc into y_out, then pulse y_valid high the following cycle for exactly one cycle.
REQ-022 Arithmetic SHALL be signed, sign-extended to ACC_W; acc wraps modulo 2^ACC_W.
REQ-023 Fill counter, 0..4: increment on x_ld, saturate at 4.
REQ-024 primed SHALL be high iff fill counter = 4.
REQ-025 ovf SHALL set when a y_ld capture exceeds the signed DATA_W range, and clear only on reset.
REQ-026 With no strobes asserted, all state SHALL hold.

Reset
REQ-027 Reset SHALL clear taps, acc, fill counter, y_out, y_valid, primed and ovf to 0 on the next clk edge.
REQ-028 Reset SHALL override all strobes; reset mid-frame discards the partial sum.

Configuration
REQ-029 Macro FIR_SAT_EN defined: out-of-range captures SHALL clamp y_out to +2^(DATA_W-1)-1 or -2^(DATA_W-1).
REQ-030 Macro FIR_SAT_EN undefined: y_out SHALL be acc[DATA_W-1:0] (wrap).
REQ-031 ovf behaves identically in both builds.

Structure
REQ-032 The shared package SHALL hold the mult_sel encodings (TAP0..TAP3 = 2'b00..2'b11) and the default coefficient constants.
REQ-033 A sub-module fir_mac SHALL contain the multiplier, accumulator and clear/load logic; the tap shift register and output stage stay in fir_datapath.

Verification
REQ-034 Reset test: assert reset 2 cycles -> y_out=0, y_valid=0, primed=0, ovf=0.
REQ-035 Impulse test: frames (x_ld; sum_clr+sum_ld sel0; sum_ld sel1..3; y_ld) with x=10,0,0,0 -> y_out=10,20,30,40; primed rises after 4th x_ld.
REQ-036 Saturation test, DATA_W=8: x=127 for four frames -> 4th y_out=127, ovf=1 with FIR_SAT_EN; y_out=-10, ovf=1 without.
REQ-037 Negative saturation: x=-128 for four frames -> y_out=-128 with FIR_SAT_EN, 0 without; ovf=1.
REQ-038 Simultaneity test: x_ld+sum_ld same cycle, and y_ld+sum_ld same cycle -> pre-shift taps used; y_out equals pre-update acc.
REQ-039 Mid-frame reset: reset after sum_ld sel1, then full frame with x=5 -> y_out=5, primed=0.
